// File: rtl/de10_mem_arbiter_if.sv
// Bundle of the two core request ports and the memory bus seen by the arbiter.
interface de10_mem_arbiter_if;
  // Instruction-fetch port
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_done;
  logic [31:0] i_rdata;
  // Load/store port
  logic        d_req;
  logic [31:0] d_addr;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        err;
  // Memory bus towards the bus controller
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  // Arbiter side
  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_we, d_be, d_wdata, mem_rdata, mem_ready,
    output i_done, i_rdata, d_done, d_rdata, err, mem_addr, mem_we, mem_be, mem_wdata
  );

  // Core / bus-controller side
  modport master (
    output i_req, i_addr, d_req, d_addr, d_we, d_be, d_wdata, mem_rdata, mem_ready,
    input  i_done, i_rdata, d_done, d_rdata, err, mem_addr, mem_we, mem_be, mem_wdata
  );
endinterface

// File: rtl/de10_mem_arbiter.sv
// Two-master arbiter (instruction fetch + load/store) onto the DE10 memory bus,
// with bounded d-port streaks and a per-transaction timeout.
module de10_mem_arbiter #(
  parameter int unsigned D_STREAK_MAX = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input logic               clk,
  input logic               rst_n,
  de10_mem_arbiter_if.slave bus
);

  localparam int unsigned SW = $clog2(D_STREAK_MAX + 1);
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e        state_q;
  logic          owner_d_q;
  logic [SW-1:0] streak_q;
  logic [SW-1:0] streak_d;
  logic [CW-1:0] cnt_q;
  logic [31:0]   mem_addr_q;
  logic          mem_we_q;
  logic [3:0]    mem_be_q;
  logic [31:0]   mem_wdata_q;
  logic          i_done_q;
  logic          d_done_q;
  logic          err_q;
  logic [31:0]   i_rdata_q;
  logic [31:0]   d_rdata_q;
  logic          grant_i_c;
  logic          timeout_hit_c;

  // Grant decision and next streak count for a grant made in IDLE
  always_comb begin
    grant_i_c     = bus.i_req && (!bus.d_req || (streak_q == SW'(D_STREAK_MAX)));
    timeout_hit_c = (cnt_q == CW'(TIMEOUT - 1));
    streak_d      = streak_q;
    if (grant_i_c) begin
      streak_d = '0;
    end else if (bus.d_req) begin
      streak_d = bus.i_req ? (streak_q + SW'(1)) : '0;
    end
  end

  // Arbitration FSM with registered bus and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_d_q   <= 1'b0;
      streak_q    <= '0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      err_q       <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.i_req || bus.d_req) begin
            streak_q  <= streak_d;
            owner_d_q <= !grant_i_c;
            cnt_q     <= '0;
            state_q   <= BUSY;
            if (grant_i_c) begin
              mem_addr_q <= bus.i_addr;
              mem_we_q   <= 1'b0;
              mem_be_q   <= 4'hF;
            end else begin
              mem_addr_q  <= bus.d_addr;
              mem_we_q    <= bus.d_we;
              mem_be_q    <= bus.d_be;
              mem_wdata_q <= bus.d_wdata;
            end
          end
        end
        BUSY: begin
          if (bus.mem_ready || timeout_hit_c) begin
            // A ready arriving on the timeout cycle still counts as success
            mem_we_q <= 1'b0;
            cnt_q    <= '0;
            err_q    <= !bus.mem_ready;
            state_q  <= RESP;
            if (owner_d_q) begin
              d_done_q  <= 1'b1;
              d_rdata_q <= bus.mem_ready ? bus.mem_rdata : '0;
            end else begin
              i_done_q  <= 1'b1;
              i_rdata_q <= bus.mem_ready ? bus.mem_rdata : '0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RESP: begin
          // mem_addr stays put: the controller decodes data by last cycle's address
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_done    = i_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.err       = err_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule
